// File: rtl/mem_port_arbiter.sv
// Shares one synchronous data-memory port between the CPU and a DMA engine:
// combinational round-robin grant with DMA burst lock and CPU anti-starvation.
module mem_port_arbiter #(
  parameter int unsigned CPU_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic [3:0]  dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic        dma_lock,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        mem_read_en,
  output logic [3:0]  mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef struct packed {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

  logic       last_gnt;   // 0 = CPU, 1 = DMA
  logic [3:0] cpu_wait;
  logic       rd_pend;
  logic       rd_owner;   // 0 = CPU, 1 = DMA
  logic       dma_hold;
  logic       any_gnt;
  acc_t       cpu_acc, dma_acc, sel;

  assign cpu_acc = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign dma_acc = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};

  // A locked DMA keeps a contested port only until the CPU has waited long enough.
  assign dma_hold  = dma_lock & last_gnt & (cpu_wait < MAX_WAIT);
  assign cpu_gnt   = rst & cpu_req & (~dma_req | (last_gnt & ~dma_hold));
  assign dma_gnt   = rst & dma_req & (~cpu_req | dma_hold | ~last_gnt);
  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign any_gnt   = cpu_gnt | dma_gnt;

  always_comb begin
    sel = '0;
    if (cpu_gnt)      sel = cpu_acc;
    else if (dma_gnt) sel = dma_acc;
  end

  assign mem_read_en    = any_gnt & (sel.we == 4'h0);
  assign mem_write_en   = sel.we;
  assign mem_addr       = sel.addr;
  assign mem_write_data = sel.wdata;

  assign cpu_rvalid = rd_pend & ~rd_owner;
  assign dma_rvalid = rd_pend & rd_owner;
  assign cpu_rdata  = cpu_rvalid ? mem_read_data : 32'h0;
  assign dma_rdata  = dma_rvalid ? mem_read_data : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt <= 1'b1;
      cpu_wait <= 4'h0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      if (any_gnt) last_gnt <= dma_gnt;
      if (cpu_stall) cpu_wait <= (cpu_wait >= MAX_WAIT) ? MAX_WAIT : cpu_wait + 4'd1;
      else           cpu_wait <= 4'h0;
      rd_pend  <= mem_read_en;
      rd_owner <= dma_gnt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a driver predicts each cycle's access
// from the arbitration rules; an independent monitor compares DUT outputs.
module tb_mem_port_arbiter;
  localparam int MAXW = 4;

  logic        clk = 0;
  logic        rst = 0;
  logic        cpu_req = 0, dma_req = 0, dma_lock = 0;
  logic [3:0]  cpu_we = 0, dma_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_read_en;
  logic [3:0]  mem_write_en;
  logic [31:0] mem_addr, mem_write_data;
  logic [31:0] mem_read_data = 0;

  mem_port_arbiter #(.CPU_MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[31:16]} ^ 32'h3C5AA5C3;
  endfunction

  // Synchronous memory: data for the sampled address appears the next cycle.
  always @(posedge clk) mem_read_data <= mem_read_en ? memfn(mem_addr) : $urandom();

  typedef struct {
    int          cyc;
    logic        cg, dg, stall, re;
    logic [3:0]  we;
    logic [31:0] addr, wd;
  } acc_t;
  typedef struct {
    int          due;
    logic        owner;
    logic [31:0] data;
  } rd_t;

  acc_t exp_acc[$];
  rd_t  exp_rd[$];
  int   n_tests = 0, n_fail = 0;

  // Reference state: who was served last and how long the CPU has been refused.
  logic m_last = 1;
  int   m_wait = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // who: 0 none, 1 CPU, 2 DMA
  task automatic step(input logic r,
                      input logic cr, input logic [3:0] cw, input logic [31:0] ca, input logic [31:0] cd,
                      input logic dr, input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
                      input logic lk, output int who);
    acc_t e;
    rd_t  rr;
    @(posedge clk); #1;
    rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd; dma_lock = lk;
    who = 0;
    if (!r) begin
      m_last = 1; m_wait = 0;
      exp_rd.delete();
    end else if (cr && dr) begin
      if (lk && m_last && m_wait < MAXW) who = 2;
      else who = m_last ? 1 : 2;
    end else if (cr) who = 1;
    else if (dr) who = 2;
    e.cyc = cyc; e.cg = (who == 1); e.dg = (who == 2); e.stall = cr && (who != 1);
    e.we = 0; e.addr = 0; e.wd = 0;
    if (who == 1) begin e.we = cw; e.addr = ca; e.wd = cd; end
    if (who == 2) begin e.we = dw; e.addr = da; e.wd = dd; end
    e.re = (who != 0) && (e.we == 0);
    if (e.re) begin
      rr.due = cyc + 1; rr.owner = (who == 2); rr.data = memfn(e.addr);
      exp_rd.push_back(rr);
    end
    if (r) begin
      if (who != 0) m_last = (who == 2);
      m_wait = e.stall ? ((m_wait + 1 > MAXW) ? MAXW : m_wait + 1) : 0;
    end
    exp_acc.push_back(e);
  endtask

  // Monitor: one access record per cycle, plus any read return due now.
  initial begin
    acc_t e;
    rd_t  r;
    logic cv, dv;
    logic [31:0] dat;
    forever begin
      @(negedge clk);
      if (exp_acc.size() > 0 && exp_acc[0].cyc == cyc) begin
        e = exp_acc.pop_front();
        chk("grant", {61'b0, cpu_gnt, dma_gnt, cpu_stall}, {61'b0, e.cg, e.dg, e.stall});
        chk("mem_ctl", {59'b0, mem_read_en, mem_write_en}, {59'b0, e.re, e.we});
        chk("mem_addr_wd", {mem_addr, mem_write_data}, {e.addr, e.wd});
      end
      cv = 0; dv = 0; dat = 0;
      if (exp_rd.size() > 0 && exp_rd[0].due == cyc) begin
        r = exp_rd.pop_front();
        cv = ~r.owner; dv = r.owner; dat = r.data;
      end
      chk("rvalid", {62'b0, cpu_rvalid, dma_rvalid}, {62'b0, cv, dv});
      chk("rdata", {cpu_rdata, dma_rdata}, {cv ? dat : 32'h0, dv ? dat : 32'h0});
    end
  end

  initial begin
    int w, ndma;
    logic c_pend, d_pend, lk;
    logic [3:0] c_we, d_we;
    logic [31:0] c_a, c_d, d_a, d_d;

    step(0, 0,0,0,0, 0,0,0,0, 0, w);
    step(0, 1,0,32'h40,0, 1,0,32'h80,0, 1, w);  // requests ignored in reset

    // CPU-only read of 0x100
    step(1, 1,0,32'h100,0, 0,0,0,0, 0, w);
    step(1, 0,0,0,0, 0,0,0,0, 0, w);

    // Continuous contention without lock alternates, CPU first
    step(0, 0,0,0,0, 0,0,0,0, 0, w);
    for (int i = 0; i < 6; i++)
      step(1, 1,0,32'h200 + 32'(i*4),0, 1,0,32'h300 + 32'(i*4),0, 0, w);

    // Locked DMA burst of 10 reads; CPU joins from the second cycle
    step(0, 0,0,0,0, 0,0,0,0, 0, w);
    ndma = 0;
    for (int i = 0; i < 20 && ndma < 10; i++) begin
      step(1, i > 0,0,32'h1000,0, 1,0,32'h2000 + 32'(ndma*4),0, 1, w);
      if (w == 2) ndma++;
    end
    chk("burst_done", 64'(ndma), 64'd10);

    // CPU byte write concurrent with DMA read
    step(0, 0,0,0,0, 0,0,0,0, 0, w);
    step(1, 1,4'b0010,32'h44,32'hAA, 1,0,32'h88,0, 0, w);
    step(1, 0,0,0,0, 1,0,32'h88,0, 0, w);
    step(1, 0,0,0,0, 0,0,0,0, 0, w);

    // Reset the cycle after a granted DMA read; tie after release goes to CPU
    step(1, 0,0,0,0, 1,0,32'h500,0, 0, w);
    step(0, 0,0,0,0, 0,0,0,0, 0, w);
    step(0, 0,0,0,0, 0,0,0,0, 0, w);
    step(1, 1,0,32'h600,0, 1,0,32'h700,0, 0, w);
    step(1, 0,0,0,0, 1,0,32'h700,0, 0, w);

    // CPU drops while stalled under a lock; its wait restarts
    step(0, 0,0,0,0, 0,0,0,0, 0, w);
    step(1, 0,0,0,0, 1,0,32'h800,0, 1, w);
    step(1, 1,0,32'h900,0, 1,0,32'h804,0, 1, w);
    step(1, 1,0,32'h900,0, 1,0,32'h808,0, 1, w);
    step(1, 0,0,0,0, 1,0,32'h80C,0, 1, w);
    for (int i = 0; i < 7; i++) step(1, 1,0,32'h900,0, 1,0,32'h810,0, 1, w);

    // Randomized traffic; requests hold until granted or legally dropped
    c_pend = 0; d_pend = 0; lk = 0;
    c_we = 0; d_we = 0; c_a = 0; c_d = 0; d_a = 0; d_d = 0;
    for (int i = 0; i < 600; i++) begin
      logic cr, dr;
      if (i % 16 == 0) lk = ($urandom_range(0, 1) == 1);
      if (!c_pend && $urandom_range(0, 9) < 6) begin
        c_pend = 1; c_we = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'h0;
        c_a = {$urandom_range(0, 255), 2'b00}; c_d = $urandom();
      end else if (c_pend && $urandom_range(0, 19) == 0) c_pend = 0;
      if (!d_pend && $urandom_range(0, 9) < 7) begin
        d_pend = 1; d_we = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'h0;
        d_a = {$urandom_range(0, 255), 2'b00}; d_d = $urandom();
      end else if (d_pend && $urandom_range(0, 19) == 0) d_pend = 0;
      cr = c_pend; dr = d_pend;
      step(($urandom_range(0, 99) != 0), cr, c_we, c_a, c_d, dr, d_we, d_a, d_d,
           lk && ($urandom_range(0, 7) != 0), w);
      if (w == 1) c_pend = 0;
      if (w == 2) d_pend = 0;
    end

    step(1, 0,0,0,0, 0,0,0,0, 0, w);
    step(1, 0,0,0,0, 0,0,0,0, 0, w);
    @(posedge clk); @(negedge clk);
    chk("drain_rd", 64'(exp_rd.size()), 64'd0);
    chk("drain_acc", 64'(exp_acc.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single synchronous data-memory port between the CPU data side and a DMA/accelerator engine. It sits between the pipeline's memory-stage outputs and the data memory. It issues a zero-latency combinational grant and returns read data one cycle later, tagged to its owner. Arbitration is round-robin, with a DMA lock for bursts and a bounded-wait override that protects the CPU from starvation. The CPU pipeline enable is gated by `cpu_stall`.

## Interface
Parameters:
- `CPU_MAX_WAIT`, default 4: consecutive stalled CPU cycles after which the CPU overrides a DMA lock (range 1..15).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  CPU memory access request
- `cpu_we`  in  4  CPU byte write enables; nonzero means write, zero means read
- `cpu_addr`  in  32  CPU byte address
- `cpu_wdata`  in  32  CPU write data
- `cpu_gnt`  out  1  CPU access is issued to memory this cycle
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`; drives CPU pipeline enable low
- `cpu_rvalid`  out  1  CPU read data valid
- `cpu_rdata`  out  32  CPU read data
- `dma_req`, `dma_we[3:0]`, `dma_addr[31:0]`, `dma_wdata[31:0]`  in  DMA request; same meaning as CPU
- `dma_lock`  in  1  DMA asks to keep ownership across consecutive accesses
- `dma_gnt`  out  1  DMA access issued this cycle
- `dma_rvalid`  out  1  DMA read data valid
- `dma_rdata`  out  32  DMA read data
- `mem_read_en`  out  1  memory read strobe
- `mem_write_en`  out  4  memory byte write strobes
- `mem_addr`  out  32  memory address
- `mem_write_data`  out  32  memory write data
- `mem_read_data`  in  32  memory read data, valid the cycle after `mem_read_en`

## Operation
- State:
  - `last_gnt`: 0 = CPU, 1 = DMA.
  - `cpu_wait`: 4-bit counter.
  - `rd_pend`: read outstanding.
  - `rd_owner`: owner of the outstanding read.
- Grant (combinational, at most one of `cpu_gnt`/`dma_gnt` high):
  - Only one requester: that requester is granted.
  - Both request, `dma_lock` = 1, `last_gnt` = DMA, and `cpu_wait` < `CPU_MAX_WAIT`: DMA is granted.
  - Both request otherwise: the requester not equal to `last_gnt` is granted.
- Memory mux:
  - Granted requester's `we`, `addr` and `wdata` drive the memory port.
  - `mem_read_en` = grant & (`we` == 0).
  - `mem_write_en` = `we` when granted, else 0.
  - No grant: all memory outputs are 0.
- `last_gnt` updates to the granted requester on any grant and holds otherwise.
- `cpu_wait`:
  - Increments, saturating at `CPU_MAX_WAIT`, when `cpu_stall` is high.
  - Clears when `cpu_gnt` is high or `cpu_req` is low.
- Read return:
  - On a granted read, set `rd_pend` = 1 and `rd_owner` = granted requester; otherwise `rd_pend` = 0.
  - `x_rvalid` = `rd_pend & (rd_owner == x)`.
  - `x_rdata` = `mem_read_data` when that requester's `rvalid` is high, else 0.
- Requesters hold `req`, `we`, `addr` and `wdata` stable until granted. Dropping `req` before grant is legal and has no side effect.
- Writes never produce `rvalid`.

## Timing
- Grant: 0 cycles, same cycle as request.
- Read data: `rvalid` exactly 1 cycle after the granted read cycle.
- Throughput: one access per cycle. Back-to-back reads from alternating owners each return `rvalid` to the correct owner on consecutive cycles.
- Reset values, applied asynchronously while `rst` = 0:
  - `last_gnt` = DMA, so the CPU wins the first tie.
  - `cpu_wait` = 0, `rd_pend` = 0.
  - All `rvalid`/`rdata` = 0.
  - Grants and memory strobes are 0 while `rst` = 0, regardless of requests.
- Reset mid-read: the pending read is discarded and no `rvalid` follows the reset release.
- Simultaneous `cpu_wait` == `CPU_MAX_WAIT` and `dma_lock`: CPU wins; `cpu_wait` clears next cycle.
- `dma_lock` without `dma_req`: no effect.

## Test plan
- CPU-only read of `addr` 0x100, memory returns 0xDEADBEEF → `cpu_gnt` = 1 and `mem_read_en` = 1 in cycle 0; `cpu_rvalid` = 1 with `cpu_rdata` = 0xDEADBEEF in cycle 1; `dma_rvalid` = 0.
- Both request continuously, no lock, first request just after reset → grants alternate CPU, DMA, CPU, DMA; `cpu_stall` = 1 on DMA cycles.
- DMA locked burst of 10 reads, `CPU_MAX_WAIT` = 4, CPU requests from cycle 1 → DMA holds cycles 0-4, CPU is granted at cycle 5, DMA resumes at cycle 6.
- CPU byte write `cpu_we` = 4'b0010, `wdata` 0x000000AA, concurrent DMA read → CPU granted first with `mem_write_en` = 0010; DMA granted next with `dma_rvalid` one cycle later; no `cpu_rvalid`.
- Reset asserted the cycle after a granted DMA read → `dma_rvalid` stays 0 through and after release; first post-reset tie goes to the CPU.
- CPU drops `cpu_req` while stalled → `cpu_wait` clears to 0 and no memory access is issued for the CPU.
